// File: rtl/param_commit_ctrl.sv
// Parameter packet sequencer: loads UART bytes into a shadow bank and commits it atomically at frame_start.
// Optional PKT_CHECKSUM_EN: last byte must equal the XOR of all preceding bytes, else the packet is dropped.
module param_commit_ctrl #(
  parameter int NBYTES      = 54,
  parameter int IDXW        = 6,
  parameter int TIMEOUT_CYC = 65535,
  parameter int TW          = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            update_reg,
  input  logic [IDXW-1:0] idx,
  input  logic [7:0]      read_data,
  input  logic            pc_ready,
  input  logic            frame_start,
  input  logic [IDXW-1:0] rd_idx,
  output logic [7:0]      rd_data,
  output logic            params_valid,
  output logic            commit,
  output logic            pending,
  output logic            err_seq,
  output logic            err_timeout,
  output logic            err_overrun,
  output logic [7:0]      commit_count
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PEND, S_COMMIT} state_t;

  localparam logic [IDXW-1:0] LP_NB   = IDXW'(NBYTES);
  localparam logic [TW-1:0]   LP_TMAX = TW'(TIMEOUT_CYC - 1);

  state_t          r_state, w_next;
  logic [IDXW-1:0] r_expect;
  logic [TW-1:0]   r_timer;
  logic [7:0]      r_shadow [NBYTES];
  logic [7:0]      r_active [NBYTES];
  logic            r_err_seq, r_err_to, r_err_ov;

  logic w_accept, w_start, w_err_seq, w_err_to, w_err_ov, w_timer_inc, w_commit;
  logic w_csum_ok;

`ifdef PKT_CHECKSUM_EN
  logic [7:0] r_xor;
  // XOR over every byte including the checksum is zero for a good packet.
  assign w_csum_ok = (r_xor == 8'h00);
`else
  assign w_csum_ok = 1'b1;
`endif

  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_start     = 1'b0;
    w_err_seq   = 1'b0;
    w_err_to    = 1'b0;
    w_err_ov    = 1'b0;
    w_timer_inc = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (update_reg) begin
          if (idx == '0) begin
            w_accept = 1'b1;
            w_start  = 1'b1;
            w_next   = S_LOAD;
          end else begin
            w_err_seq = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (update_reg) begin
          if (idx == r_expect && r_expect < LP_NB) begin
            w_accept = 1'b1;
          end else if (idx == '0) begin
            w_err_seq = 1'b1;
            w_accept  = 1'b1;
            w_start   = 1'b1;
          end else begin
            w_err_seq = 1'b1;
            w_next    = S_IDLE;
          end
        end else if (pc_ready) begin
          if (r_expect == LP_NB && w_csum_ok) begin
            w_next = S_PEND;
          end else begin
            w_err_seq = 1'b1;
            w_next    = S_IDLE;
          end
        end else if (r_timer == LP_TMAX) begin
          w_err_to = 1'b1;
          w_next   = S_IDLE;
        end else begin
          w_timer_inc = 1'b1;
        end
      end
      S_PEND: begin
        if (frame_start) begin
          w_next    = S_COMMIT;
          w_err_seq = update_reg;
        end else if (update_reg) begin
          if (idx == '0) begin
            w_err_ov = 1'b1;
            w_accept = 1'b1;
            w_start  = 1'b1;
            w_next   = S_LOAD;
          end else begin
            w_err_seq = 1'b1;
          end
        end
      end
      S_COMMIT: begin
        // Shadow is copied on this edge, so a new idx 0 byte may overwrite it at the same time.
        w_commit = 1'b1;
        w_next   = S_IDLE;
        if (update_reg) begin
          if (idx == '0) begin
            w_accept = 1'b1;
            w_start  = 1'b1;
            w_next   = S_LOAD;
          end else begin
            w_err_seq = 1'b1;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_expect     <= '0;
      r_timer      <= '0;
      r_err_seq    <= 1'b0;
      r_err_to     <= 1'b0;
      r_err_ov     <= 1'b0;
      params_valid <= 1'b0;
      commit_count <= 8'h00;
      rd_data      <= 8'h00;
      for (int i = 0; i < NBYTES; i++) begin
        r_shadow[i] <= 8'h00;
        r_active[i] <= 8'h00;
      end
    end else begin
      r_state   <= w_next;
      r_err_seq <= w_err_seq;
      r_err_to  <= w_err_to;
      r_err_ov  <= w_err_ov;
      if (w_accept) begin
        r_shadow[idx] <= read_data;
        r_expect      <= idx + 1'b1;
        r_timer       <= '0;
      end else if (w_timer_inc) begin
        r_timer <= r_timer + 1'b1;
      end
      if (w_commit) begin
        r_active     <= r_shadow;
        params_valid <= 1'b1;
        commit_count <= commit_count + 8'd1;
      end
      rd_data <= (rd_idx < LP_NB) ? r_active[rd_idx] : 8'h00;
    end
  end

`ifdef PKT_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_xor <= 8'h00;
    end else if (w_accept) begin
      r_xor <= w_start ? read_data : (r_xor ^ read_data);
    end
  end
`endif

  assign pending     = (r_state == S_PEND);
  assign commit      = (r_state == S_COMMIT);
  assign err_seq     = r_err_seq;
  assign err_timeout = r_err_to;
  assign err_overrun = r_err_ov;

endmodule

// File: tb/tb_param_commit_ctrl.sv
// Directed bench for param_commit_ctrl (small TIMEOUT_CYC); covers checksum mode when PKT_CHECKSUM_EN is defined.
module tb_param_commit_ctrl;
  localparam int NB = 54;
  localparam int IW = 6;
  localparam int TO = 200;

  logic          clk, reset, update_reg, pc_ready, frame_start;
  logic [IW-1:0] idx, rd_idx;
  logic [7:0]    read_data, rd_data, commit_count;
  logic          params_valid, commit, pending, err_seq, err_timeout, err_overrun;
  int            checks = 0;
  int            errors = 0;

  param_commit_ctrl #(.NBYTES(NB), .IDXW(IW), .TIMEOUT_CYC(TO), .TW(16)) dut (
    .clk(clk), .reset(reset), .update_reg(update_reg), .idx(idx), .read_data(read_data),
    .pc_ready(pc_ready), .frame_start(frame_start), .rd_idx(rd_idx), .rd_data(rd_data),
    .params_valid(params_valid), .commit(commit), .pending(pending), .err_seq(err_seq),
    .err_timeout(err_timeout), .err_overrun(err_overrun), .commit_count(commit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pkt_byte(input logic [7:0] base, input int i);
    logic [7:0] x;
    x = base + 8'(i);
`ifdef PKT_CHECKSUM_EN
    if (i == NB - 1) begin
      x = 8'h00;
      for (int j = 0; j < NB - 1; j++) x = x ^ (base + 8'(j));
    end
`endif
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input int i, input logic [7:0] d);
    update_reg = 1'b1;
    idx        = IW'(i);
    read_data  = d;
    tick();
    update_reg = 1'b0;
  endtask

  task automatic send_range(input logic [7:0] base, input int lo, input int hi, input int gap);
    for (int i = lo; i <= hi; i++) begin
      send_byte(i, pkt_byte(base, i));
      repeat (gap) tick();
    end
  endtask

  task automatic pulse_pc();
    pc_ready = 1'b1;
    tick();
    pc_ready = 1'b0;
  endtask

  task automatic do_commit();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; update_reg = 1'b0; pc_ready = 1'b0; frame_start = 1'b0;
    idx = '0; read_data = 8'h00; rd_idx = '0;
    #3;
    checks++;
    if ({params_valid, commit, pending, err_seq, err_timeout, err_overrun} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 000000",
        {params_valid, commit, pending, err_seq, err_timeout, err_overrun});
    end
    checks++;
    if (commit_count !== 8'h00 || rd_data !== 8'h00) begin
      errors++; $display("FAIL reset_data: got count=%0h rd=%0h expected 0/0", commit_count, rd_data);
    end
    tick(); tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_commit();
    rd_idx = 6'd10;
    send_range(8'h00, 0, NB - 1, 100);
    pulse_pc();
    checks++;
    if (pending !== 1'b1) begin errors++; $display("FAIL commit_pend: got %b expected 1", pending); end
    repeat (50) tick();
    checks++;
    if (pending !== 1'b1 || commit !== 1'b0) begin
      errors++; $display("FAIL commit_wait: got pend=%b commit=%b expected 1/0", pending, commit);
    end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    checks++;
    if (commit !== 1'b1 || commit_count !== 8'd0) begin
      errors++; $display("FAIL commit_pulse: got commit=%b count=%0d expected 1/0", commit, commit_count);
    end
    tick();
    checks++;
    if (commit !== 1'b0 || commit_count !== 8'd1 || params_valid !== 1'b1) begin
      errors++; $display("FAIL commit_after: got commit=%b count=%0d pv=%b expected 0/1/1",
        commit, commit_count, params_valid);
    end
    checks++;
    if (rd_data !== 8'h00) begin errors++; $display("FAIL commit_old_read: got %0h expected 0", rd_data); end
    tick();
    checks++;
    if (rd_data !== 8'h0A) begin errors++; $display("FAIL commit_read10: got %0h expected 0a", rd_data); end
    rd_idx = 6'd60;
    tick();
    checks++;
    if (rd_data !== 8'h00) begin errors++; $display("FAIL read_oob: got %0h expected 0", rd_data); end
    rd_idx = 6'd53;
    tick();
    checks++;
    if (rd_data !== pkt_byte(8'h00, 53)) begin
      errors++; $display("FAIL read53: got %0h expected %0h", rd_data, pkt_byte(8'h00, 53));
    end
  endtask

  task automatic test_seq_error();
    rd_idx = 6'd5;
    send_byte(7, 8'h77);
    checks++;
    if (err_seq !== 1'b1) begin errors++; $display("FAIL seq_idle: got %b expected 1", err_seq); end
    tick();
    checks++;
    if (err_seq !== 1'b0) begin errors++; $display("FAIL seq_width: got %b expected 0", err_seq); end
    send_range(8'h80, 0, 9, 2);
    send_byte(11, 8'h8B);
    checks++;
    if (err_seq !== 1'b1 || pending !== 1'b0) begin
      errors++; $display("FAIL seq_skip: got err=%b pend=%b expected 1/0", err_seq, pending);
    end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    checks++;
    if (commit !== 1'b0) begin errors++; $display("FAIL seq_nocommit: got %b expected 0", commit); end
    tick();
    checks++;
    if (commit_count !== 8'd1 || rd_data !== 8'h05) begin
      errors++; $display("FAIL seq_active: got count=%0d rd=%0h expected 1/05", commit_count, rd_data);
    end
    send_range(8'h80, 0, 3, 0);
    pulse_pc();
    checks++;
    if (err_seq !== 1'b1) begin errors++; $display("FAIL seq_early_pc: got %b expected 1", err_seq); end
  endtask

  task automatic test_timeout();
    send_range(8'h90, 0, 5, 0);
    for (int k = 1; k <= TO; k++) begin
      tick();
      if (k == TO - 1) begin
        checks++;
        if (err_timeout !== 1'b0) begin errors++; $display("FAIL timeout_early: got %b expected 0", err_timeout); end
      end
      if (k == TO) begin
        checks++;
        if (err_timeout !== 1'b1) begin errors++; $display("FAIL timeout_pulse: got %b expected 1", err_timeout); end
      end
    end
    send_range(8'h40, 0, NB - 1, 0);
    pulse_pc();
    do_commit();
    rd_idx = 6'd5;
    tick();
    checks++;
    if (commit_count !== 8'd2 || rd_data !== 8'h45) begin
      errors++; $display("FAIL timeout_recover: got count=%0d rd=%0h expected 2/45", commit_count, rd_data);
    end
  endtask

  task automatic test_overrun();
    send_range(8'h10, 0, NB - 1, 0);
    pulse_pc();
    send_byte(0, pkt_byte(8'h20, 0));
    checks++;
    if (err_overrun !== 1'b1 || pending !== 1'b0) begin
      errors++; $display("FAIL overrun: got ov=%b pend=%b expected 1/0", err_overrun, pending);
    end
    send_range(8'h20, 1, NB - 1, 0);
    pulse_pc();
    checks++;
    if (pending !== 1'b1) begin errors++; $display("FAIL overrun_pend: got %b expected 1", pending); end
    do_commit();
    rd_idx = 6'd10;
    tick();
    checks++;
    if (commit_count !== 8'd3 || rd_data !== 8'h2A) begin
      errors++; $display("FAIL overrun_data: got count=%0d rd=%0h expected 3/2a", commit_count, rd_data);
    end
  endtask

  task automatic test_back_to_back();
    send_range(8'h30, 0, NB - 1, 0);
    pc_ready = 1'b1; frame_start = 1'b1;
    tick();
    pc_ready = 1'b0; frame_start = 1'b0;
    tick();
    checks++;
    if (pending !== 1'b1 || commit !== 1'b0) begin
      errors++; $display("FAIL pc_fs_same: got pend=%b commit=%b expected 1/0", pending, commit);
    end
    update_reg = 1'b1; idx = '0; read_data = 8'hEE; frame_start = 1'b1;
    tick();
    update_reg = 1'b0; frame_start = 1'b0;
    checks++;
    if (commit !== 1'b1 || err_seq !== 1'b1) begin
      errors++; $display("FAIL fs_idx0: got commit=%b err=%b expected 1/1", commit, err_seq);
    end
    tick();
    send_byte(1, 8'h55);
    checks++;
    if (err_seq !== 1'b1 || commit_count !== 8'd4) begin
      errors++; $display("FAIL fs_drop: got err=%b count=%0d expected 1/4", err_seq, commit_count);
    end
    rd_idx = 6'd0;
    tick();
    checks++;
    if (rd_data !== 8'h30) begin errors++; $display("FAIL fs_data: got %0h expected 30", rd_data); end
  endtask

`ifdef PKT_CHECKSUM_EN
  task automatic test_checksum();
    send_range(8'h50, 0, NB - 2, 0);
    send_byte(NB - 1, pkt_byte(8'h50, NB - 1) ^ 8'h01);
    pulse_pc();
    checks++;
    if (err_seq !== 1'b1 || pending !== 1'b0) begin
      errors++; $display("FAIL csum_bad: got err=%b pend=%b expected 1/0", err_seq, pending);
    end
    do_commit();
    checks++;
    if (commit_count !== 8'd4) begin errors++; $display("FAIL csum_nocommit: got %0d expected 4", commit_count); end
    send_range(8'h50, 0, NB - 1, 0);
    pulse_pc();
    do_commit();
    rd_idx = 6'd53;
    tick();
    checks++;
    if (commit_count !== 8'd5 || rd_data !== pkt_byte(8'h50, 53)) begin
      errors++; $display("FAIL csum_good: got count=%0d rd=%0h expected 5/%0h",
        commit_count, rd_data, pkt_byte(8'h50, 53));
    end
  endtask
`endif

  task automatic test_reset_midload();
    send_range(8'h60, 0, 3, 0);
    reset = 1'b0;
    #2;
    checks++;
    if (params_valid !== 1'b0 || commit_count !== 8'd0 || rd_data !== 8'h00) begin
      errors++; $display("FAIL midreset: got pv=%b count=%0d rd=%0h expected 0/0/0",
        params_valid, commit_count, rd_data);
    end
    reset = 1'b1;
    tick();
    send_byte(4, 8'h64);
    checks++;
    if (err_seq !== 1'b1) begin errors++; $display("FAIL midreset_idle: got %b expected 1", err_seq); end
    rd_idx = 6'd0;
    tick();
    checks++;
    if (rd_data !== 8'h00) begin errors++; $display("FAIL midreset_bank: got %0h expected 0", rd_data); end
  endtask

  initial begin
    test_reset();
    test_commit();
    test_seq_error();
    test_timeout();
    test_overrun();
    test_back_to_back();
`ifdef PKT_CHECKSUM_EN
    test_checksum();
`endif
    test_reset_midload();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/param_commit_ctrl.md
Name: param_commit_ctrl

Overview:
- Sequences the 54-byte parameter packet arriving from the UART byte receiver (update_reg/idx/read_data/pc_ready strobes) into a shadow register bank.
- Validates byte order and inter-byte timing.
- Commits the complete packet atomically into an active bank at the next frame boundary (frame_start), so the raster datapath never sees a half-updated parameter set.
- Sits between the UART byte receiver and the GPU parameter consumers.

Parameters:
- NBYTES, 54, bytes per packet; expected idx runs 0..NBYTES-1.
- IDXW, 6, width of idx/rd_idx.
- TIMEOUT_CYC, 65535, maximum clk cycles allowed between consecutive bytes of one packet.
- TW, 16, width of the timeout counter; must hold TIMEOUT_CYC.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- update_reg  in  1  one-cycle strobe: read_data/idx valid
- idx  in  IDXW  byte index of read_data
- read_data  in  8  packet byte
- pc_ready  in  1  one-cycle strobe, cycle after last byte's update_reg
- frame_start  in  1  one-cycle frame boundary pulse (vsync)
- rd_idx  in  IDXW  active-bank read address
- rd_data  out  8  active-bank byte, registered
- params_valid  out  1  high from first commit until reset
- commit  out  1  one-cycle pulse when active bank updated
- pending  out  1  complete packet waiting for frame_start
- err_seq  out  1  one-cycle pulse: out-of-order idx or premature pc_ready
- err_timeout  out  1  one-cycle pulse: inter-byte gap exceeded
- err_overrun  out  1  one-cycle pulse: pending packet discarded
- commit_count  out  8  number of commits, wraps 255->0

Behaviour:
- Reset (reset=0, async): all outputs 0; both banks 0; state IDLE; expect=0; timer=0.
- States: IDLE, LOAD, PEND, COMMIT.
- IDLE, update_reg with idx==0:
  - shadow[0]<=read_data; expect<=1; timer<=0; go to LOAD.
- IDLE, update_reg with idx!=0: err_seq pulse; byte dropped; stay in IDLE.
- IDLE, pc_ready: ignored.
- LOAD, each cycle:
  - No update_reg: timer++.
  - update_reg with idx==expect: shadow[idx]<=read_data; expect++; timer<=0.
  - update_reg with idx!=expect: err_seq; go to IDLE, except idx==0, which restarts the load (shadow[0] written, expect=1).
  - timer reaching TIMEOUT_CYC: err_timeout; go to IDLE.
  - pc_ready with expect==NBYTES: go to PEND.
  - pc_ready with expect!=NBYTES: err_seq; go to IDLE.
  - update_reg and pc_ready in the same cycle: update_reg is processed; pc_ready is ignored.
- PEND:
  - pending=1.
  - frame_start: go to COMMIT.
  - update_reg with idx==0, simultaneous with frame_start: the commit takes priority; the byte is dropped with err_seq.
  - update_reg with idx==0, no frame_start: err_overrun; pending packet discarded; new load starts (shadow[0] written, go to LOAD).
  - update_reg with idx!=0: err_seq; stay in PEND.
  - frame_start in the same cycle that pc_ready enters PEND: not honoured; the commit waits for the next frame_start.
- COMMIT (1 cycle):
  - active<=shadow (all NBYTES in parallel); commit=1; params_valid<=1; commit_count++; go to IDLE.
  - A byte arriving in this cycle with idx==0 starts LOAD directly; shadow is sampled before being overwritten.
- Read port:
  - rd_data<=active[rd_idx] on every clk; 1-cycle latency.
  - rd_idx>=NBYTES returns 0.
  - In the commit cycle, rd_data returns the old value; the new value is visible on the following read.
- Shadow bytes are never read by consumers; a discarded packet leaves active untouched.
- Reset mid-load or mid-pending: everything cleared; the next packet must start at idx 0.

Optional Feature:
- Macro: PKT_CHECKSUM_EN.
- Defined:
  - byte NBYTES-1 is the XOR of bytes 0..NBYTES-2.
  - A running XOR is kept during LOAD.
  - On pc_ready with a complete packet and mismatch: err_seq pulse; go to IDLE; no commit.
  - The checksum byte is still copied to active on commit.
- Undefined: no checksum logic; every complete, in-order packet is committed.

Test Plan:
- Bytes 0x00..0x35 at idx 0..53, gaps 100 cycles, pc_ready, then frame_start 50 cycles later -> pending=1 until frame_start; commit pulse the cycle after; commit_count=1; rd_idx=10 gives rd_data=0x0A.
- Bytes idx 0..9 then idx 11 -> err_seq pulse; state IDLE; active bank unchanged; no commit at next frame_start.
- TIMEOUT_CYC=200; bytes idx 0..5, then silence -> err_timeout exactly 200 cycles after byte 5; subsequent idx 0 packet loads and commits normally.
- Full packet A pending, then packet B's idx 0 arrives before frame_start -> err_overrun; B completes; frame_start commits B's contents; A's never appear.
- pc_ready and frame_start in the same cycle -> no commit; commit on the following frame_start.
- With PKT_CHECKSUM_EN, byte 53 wrong by one bit -> err_seq after pc_ready; no commit; with correct XOR -> commit.
